regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between two requesters.
//   Port 0 (pipeline writeback) has fixed priority. Port 1 (late load return,
//   CSR unit, ...) is granted whenever port 0 is idle, and is forced through
//   after STARVE_LIMIT consecutive refused cycles. The write itself is
//   registered: one register-file write per cycle, one cycle after the
//   handshake.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   pN_valid_i / pN_ready_o  request handshake for port N (transfer on both)
//   pN_write_i               1 = real write, 0 = bubble carrying no write
//   pN_addr_i / pN_data_i    destination register / write data
//   reg_write_o              register-file write enable (registered)
//   reg_addr_o / reg_data_o  register-file write address / data (registered)
//   grant_src_o              source of the current output write (registered)
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_valid_i,
  output logic        p0_ready_o,
  input  logic        p0_write_i,
  input  logic [4:0]  p0_addr_i,
  input  logic [31:0] p0_data_i,
  input  logic        p1_valid_i,
  output logic        p1_ready_o,
  input  logic        p1_write_i,
  input  logic [4:0]  p1_addr_i,
  input  logic [31:0] p1_data_i,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic        grant_src_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             write_q, write_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             src_q, src_d;

  logic force_p1;
  logic xfer0, xfer1;

  always_comb begin
    force_p1   = p1_valid_i && (starve_cnt_q == LIMIT);
    p0_ready_o = !rst_i && !force_p1;
    p1_ready_o = !rst_i && (force_p1 || !p0_valid_i);

    // The ready equations make these mutually exclusive: port 1 is only
    // ready with port 0 valid when forced, and forcing drops port 0 ready.
    xfer0 = p0_valid_i && p0_ready_o;
    xfer1 = p1_valid_i && p1_ready_o;

    if (p1_valid_i && !p1_ready_o) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q
                                             : starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = '0;
    end

    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (xfer0) begin
      // x0 is hardwired: accept the request but never enable the write.
      write_d = p0_write_i && (p0_addr_i != '0);
      addr_d  = p0_addr_i;
      data_d  = p0_data_i;
      src_d   = 1'b0;
    end else if (xfer1) begin
      write_d = p1_write_i && (p1_addr_i != '0);
      addr_d  = p1_addr_i;
      data_d  = p1_data_i;
      src_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      src_q        <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      src_q        <= src_d;
    end
  end

  assign reg_write_o = write_q;
  assign reg_addr_o  = addr_q;
  assign reg_data_o  = data_q;
  assign grant_src_o = src_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_ready, p0_write;
  logic [4:0]  p0_addr;
  logic [31:0] p0_data;
  logic        p1_valid, p1_ready, p1_write;
  logic [4:0]  p1_addr;
  logic [31:0] p1_data;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        grant_src;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .p0_valid_i  (p0_valid),
    .p0_ready_o  (p0_ready),
    .p0_write_i  (p0_write),
    .p0_addr_i   (p0_addr),
    .p0_data_i   (p0_data),
    .p1_valid_i  (p1_valid),
    .p1_ready_o  (p1_ready),
    .p1_write_i  (p1_write),
    .p1_addr_i   (p1_addr),
    .p1_data_i   (p1_data),
    .reg_write_o (reg_write),
    .reg_addr_o  (reg_addr),
    .reg_data_o  (reg_data),
    .grant_src_o (grant_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_valid = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_data = '0;
    p1_valid = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_data = '0;
  endtask

  int k;
  logic [31:0] exp_data;

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick();

    // Reset state; readies gated even with both ports requesting.
    p0_valid = 1'b1; p1_valid = 1'b1;
    #1;
    chk("rst_p0_ready", p0_ready, 0);
    chk("rst_p1_ready", p1_ready, 0);
    chk("rst_write", reg_write, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_data", reg_data, 0);
    chk("rst_src", grant_src, 0);
    chk("rst_cnt", dut.starve_cnt_q, 0);
    idle();
    rst = 1'b0;
    tick();
    chk("post_rst_write", reg_write, 0);

    // Port 1 alone is granted immediately.
    p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 5'd5; p1_data = 32'hDEADBEEF;
    #1;
    chk("p1only_p1_ready", p1_ready, 1);
    chk("p1only_p0_ready", p0_ready, 1);
    tick();
    chk("p1only_write", reg_write, 1);
    chk("p1only_addr", reg_addr, 5);
    chk("p1only_data", reg_data, 32'hDEADBEEF);
    chk("p1only_src", grant_src, 1);
    idle();
    tick();
    chk("hold_write", reg_write, 0);
    chk("hold_addr", reg_addr, 5);
    chk("hold_data", reg_data, 32'hDEADBEEF);
    chk("hold_src", grant_src, 1);

    // Continuous contention: grants 0,0,0,0,1,0; counter 1,2,3,4,0,1.
    k = 0;
    p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 5'd7; p1_data = 32'hAAAA0000;
    for (int i = 0; i < 6; i++) begin
      p0_valid = 1'b1; p0_write = 1'b1;
      p0_addr = 5'(8 + k); p0_data = 32'h100 + 32'(k);
      #1;
      chk("cont_p0_ready", p0_ready, (i == 4) ? 0 : 1);
      chk("cont_p1_ready", p1_ready, (i == 4) ? 1 : 0);
      exp_data = (i == 4) ? p1_data : p0_data;
      tick();
      chk("cont_src", grant_src, (i == 4) ? 1 : 0);
      chk("cont_write", reg_write, 1);
      chk("cont_data", reg_data, exp_data);
      chk("cont_cnt", dut.starve_cnt_q, (i == 4) ? 0 : ((i == 5) ? 1 : i + 1));
      if (i == 4) p1_data = 32'hAAAA0001;
      else        k++;
    end
    idle();
    tick();
    chk("cont_cnt_clear", dut.starve_cnt_q, 0);

    // x0: accepted, but no write enable.
    p0_valid = 1'b1; p0_write = 1'b1; p0_addr = 5'd0; p0_data = 32'h12345678;
    #1;
    chk("x0_ready", p0_ready, 1);
    tick();
    chk("x0_write", reg_write, 0);
    chk("x0_data", reg_data, 32'h12345678);
    chk("x0_src", grant_src, 0);
    idle();

    // Bubble on port 0 still wins over port 1.
    p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 5'd9; p0_data = 32'h55;
    p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 5'd4; p1_data = 32'h66;
    #1;
    chk("bub_p0_ready", p0_ready, 1);
    chk("bub_p1_ready", p1_ready, 0);
    tick();
    chk("bub_write", reg_write, 0);
    chk("bub_addr", reg_addr, 9);
    chk("bub_src", grant_src, 0);
    chk("bub_cnt", dut.starve_cnt_q, 1);
    idle();
    tick();
    chk("bub_cnt_clear", dut.starve_cnt_q, 0);

    // Same-register collision serialized p0 then p1.
    p0_valid = 1'b1; p0_write = 1'b1; p0_addr = 5'd3; p0_data = 32'h1;
    p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 5'd3; p1_data = 32'h2;
    tick();
    chk("col1_write", reg_write, 1);
    chk("col1_addr", reg_addr, 3);
    chk("col1_data", reg_data, 32'h1);
    p0_valid = 1'b0;
    #1;
    chk("col2_p1_ready", p1_ready, 1);
    tick();
    chk("col2_write", reg_write, 1);
    chk("col2_addr", reg_addr, 3);
    chk("col2_data", reg_data, 32'h2);
    chk("col2_src", grant_src, 1);
    idle();
    tick();

    // Reset mid-stream with counter at 3.
    p0_valid = 1'b1; p0_write = 1'b1; p0_addr = 5'd10; p0_data = 32'hC0;
    p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 5'd11; p1_data = 32'hC1;
    tick(); tick(); tick();
    chk("mid_cnt3", dut.starve_cnt_q, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_p0_ready", p0_ready, 0);
    chk("mid_rst_p1_ready", p1_ready, 0);
    tick();
    chk("mid_cnt0", dut.starve_cnt_q, 0);
    chk("mid_write", reg_write, 0);
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("mid_p1_ready", p1_ready, (j == 4) ? 1 : 0);
      chk("mid_p0_ready", p0_ready, (j == 4) ? 0 : 1);
      tick();
      chk("mid_src", grant_src, (j == 4) ? 1 : 0);
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
